// File: rtl/cook_sequencer.sv
// Cooking-cycle controller: run/pause/done sequencing, timer gating, magnetron duty and beep.
// Define COOK_SEQ_AUTO_RESUME_EN to resume a door-caused pause when the door closes again.
module cook_sequencer #(
  parameter int unsigned MAX_POWER    = 10,
  parameter int unsigned BEEP_SECONDS = 3,
  parameter int unsigned PWR_W        = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             door_closed,
  input  logic             tick,
  input  logic             timer_zero,
  input  logic [PWR_W-1:0] power_level,
  output logic             timer_enable,
  output logic             mag_on,
  output logic             beep,
  output logic [1:0]       state
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned BcW = (BEEP_SECONDS > 0) ? $clog2(BEEP_SECONDS + 1) : 1;

  localparam logic [PWR_W-1:0] MaxPw     = PWR_W'(MAX_POWER);
  localparam logic [PWR_W-1:0] PhaseLast = PWR_W'(MAX_POWER - 1);
  localparam logic [PWR_W-1:0] PhaseOne  = PWR_W'(1);
  localparam logic [BcW-1:0]   BeepLoad  = BcW'(BEEP_SECONDS);
  localparam logic [BcW-1:0]   BeepOne   = BcW'(1);

  logic [1:0]       state_q, state_d;
  logic [PWR_W-1:0] phase_q, phase_d;
  logic [BcW-1:0]   beep_cnt_q, beep_cnt_d;
  logic             beep_q;
  logic [PWR_W-1:0] eff_power;
  logic             run_door;

`ifdef COOK_SEQ_AUTO_RESUME_EN
  logic door_pause_q, door_pause_d;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    beep_cnt_d = beep_cnt_q;
`ifdef COOK_SEQ_AUTO_RESUME_EN
    door_pause_d = door_pause_q;
`endif

    // Phase advances on a RUN tick even when the state leaves RUN on the same edge.
    if (state_q == StRun && tick) begin
      phase_d = (phase_q == PhaseLast) ? '0 : phase_q + PhaseOne;
    end

    case (state_q)
      StIdle: begin
        if (start && door_closed && !timer_zero) begin
          state_d = StRun;
          phase_d = '0;
        end
      end
      StRun: begin
        if (!door_closed) begin
          state_d = StPause;
`ifdef COOK_SEQ_AUTO_RESUME_EN
          door_pause_d = 1'b1;
`endif
        end else if (stop) begin
          state_d = StPause;
        end else if (timer_zero) begin
          state_d    = StDone;
          beep_cnt_d = BeepLoad;
        end
      end
      StPause: begin
        if (stop) begin
          state_d = StIdle;
        end else if (start && door_closed) begin
          state_d = timer_zero ? StIdle : StRun;
        end
`ifdef COOK_SEQ_AUTO_RESUME_EN
        else if (door_pause_q && door_closed && !timer_zero) begin
          state_d = StRun;
        end
        if (state_d != StPause) begin
          door_pause_d = 1'b0;
        end
`endif
      end
      StDone: begin
        if (start || stop) begin
          state_d = StIdle;
        end else if (tick) begin
          beep_cnt_d = beep_cnt_q - BeepOne;
          if (beep_cnt_q == BeepOne) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= (state_d == StDone);
    end
  end

`ifdef COOK_SEQ_AUTO_RESUME_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      door_pause_q <= 1'b0;
    end else begin
      door_pause_q <= door_pause_d;
    end
  end
`endif

  // Out-of-range requests, including 0, fall back to full power.
  always_comb begin
    eff_power = power_level;
    if (power_level == '0 || power_level > MaxPw) begin
      eff_power = MaxPw;
    end
  end

  // Door gating is combinational so the magnetron drops before the state register reacts.
  assign run_door     = (state_q == StRun) && door_closed;
  assign timer_enable = run_door;
  assign mag_on       = run_door && (phase_q < eff_power);
  assign beep         = beep_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Vector-table bench for cook_sequencer with an expected-output queue and async-clear sequences.
module tb_cook_sequencer;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       tick = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] power_level = 4'd10;
  logic       timer_enable, mag_on, beep;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       start, stop, door, tick, tz;
    logic [3:0] pwr;
    logic [1:0] st;
    logic       mag, ten, bp;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];

  cook_sequencer #(
    .MAX_POWER   (10),
    .BEEP_SECONDS(3),
    .PWR_W       (4)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .tick        (tick),
    .timer_zero  (timer_zero),
    .power_level (power_level),
    .timer_enable(timer_enable),
    .mag_on      (mag_on),
    .beep        (beep),
    .state       (state)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(logic s, logic p, logic d, logic t, logic z, logic [3:0] pw,
                             logic [1:0] st, logic m, logic te, logic b);
    vec_t r;
    r.start = s; r.stop = p; r.door = d; r.tick = t; r.tz = z; r.pwr = pw;
    r.st = st; r.mag = m; r.ten = te; r.bp = b;
    return r;
  endfunction

  task automatic sample(input string name);
    logic [4:0] got, exp;
    got = {state, mag_on, timer_enable, beep};
    exp = exp_q.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {state,mag,ten,beep}=%b_%b%b%b expected %b_%b%b%b", name,
               got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t x, input string name);
    @(negedge clock);
    start = x.start; stop = x.stop; door_closed = x.door; tick = x.tick;
    timer_zero = x.tz; power_level = x.pwr;
    exp_q.push_back({x.st, x.mag, x.ten, x.bp});
    #1;
    sample(name);
  endtask

  // Assert clear between edges and expect every output low at once.
  task automatic clear_pulse(input string name);
    @(negedge clock);
    start = 1'b0; stop = 1'b0; tick = 1'b0;
    #2 clear = 1'b1;
    exp_q.push_back(5'b0);
    #1 sample(name);
    @(negedge clock);
    exp_q.push_back(5'b0);
    sample({name, "_hold"});
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Full-power cook into DONE and beep countdown.
    tbl.push_back(v(0,0,1,0,0,10, 0,0,0,0));
    tbl.push_back(v(1,0,1,0,0,10, 0,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,1,1,0,10, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,1,10, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,1,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,1,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,1,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,0,1,10, 0,0,0,0));
    // Half power, then 0 and 15 treated as full, then 9 at phase 9.
    tbl.push_back(v(1,0,1,0,0,5, 0,0,0,0));
    for (int j = 0; j < 20; j++) tbl.push_back(v(0,0,1,1,0,5, 1,((j % 10) < 5),1,0));
    for (int j = 0; j < 9; j++) tbl.push_back(v(0,0,1,1,0,0, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,0,0, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,0,15, 1,1,1,0));
    tbl.push_back(v(0,0,1,0,0,9, 1,0,1,0));
    tbl.push_back(v(0,0,1,1,0,5, 1,0,1,0));
    // Door opens at phase 3; resume must keep phase 3.
    for (int j = 0; j < 3; j++) tbl.push_back(v(0,0,1,1,0,10, 1,1,1,0));
    tbl.push_back(v(0,0,0,0,0,10, 1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,10, 2,0,0,0));
    tbl.push_back(v(0,0,1,0,0,10, 2,0,0,0));
`ifndef COOK_SEQ_AUTO_RESUME_EN
    tbl.push_back(v(0,0,1,1,0,10, 2,0,0,0));
    tbl.push_back(v(1,0,1,0,0,10, 2,0,0,0));
`endif
    tbl.push_back(v(0,0,1,0,0,3, 1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,4, 1,1,1,0));
    // Stop semantics and ignored starts in IDLE.
    tbl.push_back(v(0,1,1,0,0,4, 1,1,1,0));
    tbl.push_back(v(0,1,1,0,0,4, 2,0,0,0));
    tbl.push_back(v(1,0,0,0,0,4, 0,0,0,0));
    tbl.push_back(v(1,0,1,0,1,4, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,4, 0,0,0,0));
    // Stop with timer_zero -> PAUSE; start then -> IDLE.
    tbl.push_back(v(1,0,1,0,0,10, 0,0,0,0));
    tbl.push_back(v(0,1,1,0,1,10, 1,1,1,0));
    tbl.push_back(v(1,0,1,0,1,10, 2,0,0,0));
    tbl.push_back(v(0,0,1,0,1,10, 0,0,0,0));
    // Start cuts DONE short without restarting.
    tbl.push_back(v(1,0,1,0,0,10, 0,0,0,0));
    tbl.push_back(v(0,0,1,0,1,10, 1,1,1,0));
    tbl.push_back(v(1,0,1,0,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,0,1,10, 0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,10, 0,0,0,0));
    // Door open with stop in RUN.
    tbl.push_back(v(1,0,1,0,0,10, 0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,10, 1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,10, 2,0,0,0));
    tbl.push_back(v(0,1,0,0,0,10, 2,0,0,0));
    tbl.push_back(v(0,0,1,0,0,10, 0,0,0,0));
    // Tick on the exit edge from RUN still advances phase.
    tbl.push_back(v(1,0,1,0,0,1, 0,0,0,0));
    tbl.push_back(v(0,1,1,1,0,1, 1,1,1,0));
    tbl.push_back(v(1,0,1,0,0,1, 2,0,0,0));
    tbl.push_back(v(0,0,1,0,0,1, 1,0,1,0));
    tbl.push_back(v(0,0,1,0,0,2, 1,1,1,0));
    tbl.push_back(v(0,1,1,0,0,2, 1,1,1,0));
    tbl.push_back(v(0,1,1,0,0,2, 2,0,0,0));
    // Tick on the DONE entry edge is not counted.
    tbl.push_back(v(1,0,1,0,0,10, 0,0,0,0));
    tbl.push_back(v(0,0,1,1,1,10, 1,1,1,0));
    for (int j = 0; j < 3; j++) tbl.push_back(v(0,0,1,1,1,10, 3,0,0,1));
    tbl.push_back(v(0,0,1,0,1,10, 0,0,0,0));

    // Outputs low while clear is held from time zero.
    #1;
    exp_q.push_back(5'b0);
    sample("reset_held");
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Async clear in RUN, then in DONE.
    apply(v(1,0,1,0,0,10, 0,0,0,0), "rst_run_start");
    apply(v(0,0,1,1,0,10, 1,1,1,0), "rst_run_tick");
    clear_pulse("clear_in_run");
    apply(v(0,0,1,0,0,10, 0,0,0,0), "after_clear_idle");
    apply(v(1,0,1,0,0,1, 0,0,0,0), "after_clear_start");
    apply(v(0,0,1,0,0,1, 1,1,1,0), "after_clear_phase0");
    apply(v(0,0,1,0,1,1, 1,1,1,0), "rst_done_enter");
    apply(v(0,0,1,0,1,1, 3,0,0,1), "rst_done_beep");
    clear_pulse("clear_in_done");
    apply(v(0,0,1,0,1,1, 0,0,0,0), "after_clear_done");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
Cooking-cycle controller between the front-panel buttons and the countdown timer/magnetron datapath. It owns the run/pause/done state machine, gates the timer's count enable and drives the magnetron with a per-second duty cycle set by a power level. It also produces the end-of-cook beep. It replaces the ad-hoc start/stop latch with a sequenced controller that has explicit door, pause and power semantics.

Parameters:
MAX_POWER, 10, duty window length in seconds; also the highest power level.
BEEP_SECONDS, 3, number of 1 Hz ticks the beep is held after timer reaches zero.
PWR_W, 4, width of power_level; must hold MAX_POWER.

Ports:
clock  input  1  system clock, rising edge.
clear  input  1  asynchronous active-high reset.
start  input  1  one-cycle synchronous start pulse (debounced upstream).
stop  input  1  one-cycle synchronous stop/cancel pulse.
door_closed  input  1  level, 1 = door closed.
tick  input  1  one-cycle 1 Hz enable pulse, synchronous to clock.
timer_zero  input  1  level from timer, 1 = remaining time is 0:00.
power_level  input  PWR_W  requested power in 1..MAX_POWER; sampled every tick.
timer_enable  output  1  countdown enable to the timer.
mag_on  output  1  magnetron drive.
beep  output  1  buzzer drive.
state  output  2  current state code, for display and debug.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, phase=0, beep_cnt=0. All outputs 0 while clear is high.
- State codes: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE:
  - start & door_closed & !timer_zero -> RUN; phase cleared to 0.
  - start with door open or timer_zero=1 is ignored.
  - stop is ignored.
- RUN:
  - Transition priority: !door_closed -> PAUSE; else stop -> PAUSE; else timer_zero -> DONE.
  - start in RUN is ignored.
- PAUSE:
  - stop -> IDLE. Timer contents are untouched; the timer is cleared by the user via clear.
  - start & door_closed & !timer_zero -> RUN; phase is retained, not cleared.
  - start & door_closed & timer_zero -> IDLE.
- DONE:
  - beep=1. On entry beep_cnt loads BEEP_SECONDS. Each tick decrements beep_cnt.
  - On the tick that takes beep_cnt to 0 -> IDLE.
  - start or stop in DONE -> IDLE immediately. A start that cuts DONE short does not restart a cook.
- All state transitions are registered with 1-cycle latency from the input event.
- Tick accounting: a tick counts only if state is already RUN (or DONE, for beep_cnt) at that clock edge. A tick in the cycle a state is entered is not counted for that state.
- Duty cycle:
  - phase counts 0..MAX_POWER-1. It increments on each RUN tick and wraps MAX_POWER-1 -> 0. It holds in PAUSE.
  - eff_power = MAX_POWER if power_level is 0 or greater than MAX_POWER; otherwise eff_power = power_level.
  - mag_on = (state==RUN) & door_closed & (phase < eff_power).
  - door_closed gates mag_on combinationally, so the magnetron drops in the same cycle the door opens, before the state register updates.
- timer_enable = (state==RUN) & door_closed, with the same combinational door gating.
- beep = (state==DONE), registered.
- Simultaneous events:
  - clear overrides everything.
  - In RUN, door open and stop in the same cycle -> PAUSE.
  - In RUN, timer_zero with stop in the same cycle -> PAUSE. A later start from PAUSE then goes to IDLE.
  - tick coincident with a transition out of RUN: phase is still updated.

Optional Feature:
Macro: COOK_SEQ_AUTO_RESUME_EN.
- Defined: PAUSE entered because the door opened records a door_pause flag. When door_closed returns high while in PAUSE with door_pause=1 and !timer_zero, the block goes to RUN with no start needed. A stop-caused PAUSE still requires start. The flag clears on any exit from PAUSE and on clear.
- Undefined: no flag; every exit from PAUSE to RUN requires start.

Test Plan:
1. Full-power cook: clear pulse; door_closed=1, power_level=10, timer_zero=0; start; 5 ticks; then timer_zero=1 -> state 0->1, mag_on and timer_enable high throughout RUN. Next cycle state=3, beep=1. After 3 ticks state=0 and beep=0.
2. Half power: power_level=5, 20 ticks in RUN -> mag_on high while phase 0..4 and low while phase 5..9, repeating; exactly 10 on-seconds. power_level=0 behaves as 10.
3. Door open mid-cook: in RUN at phase 3, door_closed=0 -> mag_on and timer_enable are 0 in the same cycle, state=2 next cycle. Close the door, then start -> RUN resumes at phase 3. With COOK_SEQ_AUTO_RESUME_EN defined, closing the door alone resumes RUN.
4. Stop semantics: start, then stop -> PAUSE (state=2). A second stop -> IDLE. Start with door open in IDLE -> stays in IDLE.
5. Simultaneous and early-exit cases: in RUN, stop and timer_zero in the same cycle -> PAUSE; start -> IDLE. In DONE, a start pulse -> IDLE next cycle and beep=0.
6. Async reset mid-cook: assert clear between clock edges in RUN -> all outputs 0 immediately, state=0, phase=0 after release.
